// File: rtl/vga_pkg.sv
// Shared VGA timing constants (640x480@60 defaults) and the axis-length helper
// used by the raster timing generator and its per-axis counters.
package vga_pkg;

    localparam int H_ACTIVE_DEF = 640;
    localparam int H_FP_DEF     = 16;
    localparam int H_SYNC_DEF   = 96;
    localparam int H_BP_DEF     = 48;
    localparam int V_ACTIVE_DEF = 480;
    localparam int V_FP_DEF     = 10;
    localparam int V_SYNC_DEF   = 2;
    localparam int V_BP_DEF     = 33;
    localparam int CW_DEF       = 10;

    function automatic int axis_total(input int active, input int fp, input int sync, input int bp);
        return active + fp + sync + bp;
    endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: wrap counter with enable, same-edge wrap pulse, and registered
// sync / next-active decode so the sync output lines up with the counter value.
module vga_axis_counter
    import vga_pkg::*;
#(
    parameter int   ACTIVE = H_ACTIVE_DEF,
    parameter int   FP     = H_FP_DEF,
    parameter int   SYNC   = H_SYNC_DEF,
    parameter int   BP     = H_BP_DEF,
    parameter logic POL    = 1'b0,
    parameter int   CW     = CW_DEF
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          en,
    output logic [CW-1:0] cnt,
    output logic          wrap,
    output logic          active_next,
    output logic          sync
);

    localparam int TOTAL = axis_total(ACTIVE, FP, SYNC, BP);

    generate
        if (FP == 0 || SYNC == 0 || BP == 0) begin : g_zero_param
            $error("vga_axis_counter: porch and sync widths must be non-zero");
        end
        if (longint'(TOTAL - 1) > ((longint'(1) << CW) - 1)) begin : g_cw_too_small
            $error("vga_axis_counter: TOTAL-1 does not fit in CW bits");
        end
    endgenerate

    localparam logic [CW-1:0] LAST       = CW'(TOTAL - 1);
    localparam logic [CW-1:0] ACT_END    = CW'(ACTIVE);
    localparam logic [CW-1:0] SYNC_START = CW'(ACTIVE + FP);
    localparam logic [CW-1:0] SYNC_END   = CW'(ACTIVE + FP + SYNC);

    logic [CW-1:0] cnt_reg;
    logic [CW-1:0] cnt_next;
    logic          sync_reg;
    logic          sync_hit;

    // Decode the value the counter is about to hold, so the registered flags
    // describe the same position as cnt_reg in every cycle.
    always_comb begin
        wrap     = en && (cnt_reg == LAST);
        cnt_next = cnt_reg;
        if (en) begin
            cnt_next = wrap ? '0 : cnt_reg + CW'(1);
        end
        active_next = (cnt_next < ACT_END);
        sync_hit    = (cnt_next >= SYNC_START) && (cnt_next < SYNC_END);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_reg  <= LAST;
            sync_reg <= ~POL;
        end else begin
            cnt_reg  <= cnt_next;
            sync_reg <= sync_hit ? POL : ~POL;
        end
    end

    assign cnt  = cnt_reg;
    assign sync = sync_reg;

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: internal x/y counters with registered, aligned
// sync, blanking and start pulses. Optional frame counter under VGA_FRAME_CNT_EN.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int   H_ACTIVE  = H_ACTIVE_DEF,
    parameter int   H_FP      = H_FP_DEF,
    parameter int   H_SYNC    = H_SYNC_DEF,
    parameter int   H_BP      = H_BP_DEF,
    parameter int   V_ACTIVE  = V_ACTIVE_DEF,
    parameter int   V_FP      = V_FP_DEF,
    parameter int   V_SYNC    = V_SYNC_DEF,
    parameter int   V_BP      = V_BP_DEF,
    parameter logic HSYNC_POL = 1'b0,
    parameter logic VSYNC_POL = 1'b0,
    parameter int   CW        = CW_DEF
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          pix_en,
    output logic [CW-1:0] x,
    output logic [CW-1:0] y,
    output logic          hsync,
    output logic          vsync,
    output logic          output_en,
    output logic          line_start,
    output logic          frame_start
`ifdef VGA_FRAME_CNT_EN
    ,
    output logic [7:0]    frame_cnt
`endif
);

    logic h_wrap;
    logic v_wrap;
    logic h_active_next;
    logic v_active_next;
    logic output_en_reg;
    logic line_start_reg;
    logic frame_start_reg;

    vga_axis_counter #(
        .ACTIVE(H_ACTIVE), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP),
        .POL(HSYNC_POL), .CW(CW)
    ) u_h (
        .clk(clk), .reset(reset), .en(pix_en),
        .cnt(x), .wrap(h_wrap), .active_next(h_active_next), .sync(hsync)
    );

    // Vertical axis steps on the same edge the horizontal axis wraps.
    vga_axis_counter #(
        .ACTIVE(V_ACTIVE), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP),
        .POL(VSYNC_POL), .CW(CW)
    ) u_v (
        .clk(clk), .reset(reset), .en(h_wrap),
        .cnt(y), .wrap(v_wrap), .active_next(v_active_next), .sync(vsync)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            output_en_reg   <= 1'b0;
            line_start_reg  <= 1'b0;
            frame_start_reg <= 1'b0;
        end else begin
            output_en_reg   <= h_active_next & v_active_next;
            line_start_reg  <= h_wrap;
            frame_start_reg <= v_wrap;
        end
    end

    assign output_en   = output_en_reg;
    assign line_start  = line_start_reg;
    assign frame_start = frame_start_reg;

`ifdef VGA_FRAME_CNT_EN
    logic [7:0] frame_cnt_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            frame_cnt_reg <= 8'd0;
        end else if (v_wrap) begin
            frame_cnt_reg <= frame_cnt_reg + 8'd1;
        end
    end

    assign frame_cnt = frame_cnt_reg;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Self-checking bench for vga_timing_gen on a reduced raster, compared against
// a position-index model (ticks since reset -> linear pixel index -> x,y).
module tb_vga_timing_gen;

    localparam int   HA = 32, HF = 4, HS = 8, HB = 6;
    localparam int   VA = 20, VF = 2, VS = 3, VB = 5;
    localparam int   HT = HA + HF + HS + HB;
    localparam int   VT = VA + VF + VS + VB;
    localparam int   FT = HT * VT;
    localparam logic HPOL = 1'b1;
    localparam logic VPOL = 1'b0;
    localparam int   CW = 10;

    logic          clk;
    logic          reset;
    logic          pix_en;
    logic [CW-1:0] x, y;
    logic          hsync, vsync, output_en, line_start, frame_start;
`ifdef VGA_FRAME_CNT_EN
    logic [7:0]    frame_cnt;
`endif

    vga_timing_gen #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .HSYNC_POL(HPOL), .VSYNC_POL(VPOL), .CW(CW)
    ) dut (
        .clk(clk), .reset(reset), .pix_en(pix_en),
        .x(x), .y(y), .hsync(hsync), .vsync(vsync),
        .output_en(output_en), .line_start(line_start), .frame_start(frame_start)
`ifdef VGA_FRAME_CNT_EN
        , .frame_cnt(frame_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int n = 0;          // pix_en ticks since reset
    bit ticked = 0;     // last edge advanced the raster
    int fcnt = 0;       // frame_start pulses since reset, mod 256
    int last_fs_n = -1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got %0d exp %0d (tick %0d)", tag, got, exp, n);
        end
    endtask

    task automatic check_all();
        int p, ex, ey;
        logic e_hs, e_vs, e_oe;
        // Reset leaves the raster one pixel before (0,0).
        p  = (n + FT - 1) % FT;
        ex = p % HT;
        ey = p / HT;
        e_hs = (ex >= HA + HF && ex < HA + HF + HS) ? HPOL : ~HPOL;
        e_vs = (ey >= VA + VF && ey < VA + VF + VS) ? VPOL : ~VPOL;
        e_oe = (ex < HA) && (ey < VA);
        chk("x", 32'(x), 32'(ex));
        chk("y", 32'(y), 32'(ey));
        chk("hsync", 32'(hsync), 32'(e_hs));
        chk("vsync", 32'(vsync), 32'(e_vs));
        chk("output_en", 32'(output_en), 32'(e_oe));
        chk("line_start", 32'(line_start), 32'(ticked && ex == 0));
        chk("frame_start", 32'(frame_start), 32'(ticked && p == 0));
        if (frame_start === 1'b1) begin
            if (last_fs_n >= 0) chk("frame_period", 32'(n - last_fs_n), 32'(FT));
            last_fs_n = n;
        end
`ifdef VGA_FRAME_CNT_EN
        chk("frame_cnt", 32'(frame_cnt), 32'(fcnt));
`endif
    endtask

    task automatic cycle(input logic r, input logic e);
        reset  = r;
        pix_en = e;
        if (r) begin
            n = 0; ticked = 0; fcnt = 0; last_fs_n = -1;
        end else if (e) begin
            n++;
            ticked = 1;
            if (((n + FT - 1) % FT) == 0) fcnt = (fcnt + 1) % 256;
        end else begin
            ticked = 0;
        end
        @(negedge clk);
        check_all();
    endtask

    initial begin
        reset  = 1'b1;
        pix_en = 1'b0;

        // Reset state, with and without pix_en asserted.
        cycle(1'b1, 1'b0);
        cycle(1'b1, 1'b1);

        // First tick -> (0,0), visible, both start pulses; then over a frame continuously.
        for (int i = 0; i < FT + 100; i++) cycle(1'b0, 1'b1);

        // Random pixel enable.
        for (int i = 0; i < 3000; i++) cycle(1'b0, logic'($urandom_range(0, 3) != 0));

        // 1-of-2 pixel enable.
        for (int i = 0; i < 400; i++) cycle(1'b0, logic'(i % 2 == 0));

        // Mid-frame reset at (20,10) with pix_en held high.
        for (int i = 0; i < FT; i++) begin
            if (((n + FT - 1) % FT) == 10 * HT + 20) break;
            cycle(1'b0, 1'b1);
        end
        chk("pre_reset_x", 32'(x), 32'd20);
        chk("pre_reset_y", 32'(y), 32'd10);
        cycle(1'b1, 1'b1);
        for (int i = 0; i < 60; i++) cycle(1'b0, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
